// File: rtl/usb_sie_pkg.sv
// Shared definitions for the SIE serializer/deserializer pair.
package usb_sie_pkg;

    localparam int          DATA_WIDTH   = 8;
    localparam int          SYNC_W       = 8;
    localparam logic [7:0]  SYNC_PATTERN = 8'h80;
    localparam int          STUFF_LEN    = 6;

    localparam int          BIT_CNT_W    = $clog2(DATA_WIDTH);
    localparam int          ONES_CNT_W   = $clog2(STUFF_LEN + 1);

    typedef enum logic {
        HUNT    = 1'b0,
        RECEIVE = 1'b1
    } rx_state_e;

endpackage

// File: rtl/sipo_unstuff.sv
// Run-length tracker for received 1s; flags the bit that must be a stuffed 0.
module sipo_unstuff
    import usb_sie_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic bit_valid,
    input  logic serial_ip,
    input  logic clear,
    input  logic seed,
    output logic drop_bit,
    output logic stuff_violation
);

    logic [ONES_CNT_W-1:0] ones_cnt_q;
    logic [ONES_CNT_W-1:0] ones_cnt_d;
    logic                  at_limit;

    assign at_limit        = (ones_cnt_q == ONES_CNT_W'(STUFF_LEN));
    assign drop_bit        = bit_valid & at_limit & ~serial_ip;
    assign stuff_violation = bit_valid & at_limit &  serial_ip;

    // Next run length: seed counts the trailing SYNC 1; a stuffed bit restarts the run.
    always_comb begin
        ones_cnt_d = ones_cnt_q;
        if (clear) begin
            ones_cnt_d = '0;
        end else if (seed) begin
            ones_cnt_d = ONES_CNT_W'(1);
        end else if (bit_valid) begin
            if (at_limit || !serial_ip) begin
                ones_cnt_d = '0;
            end else begin
                ones_cnt_d = ones_cnt_q + ONES_CNT_W'(1);
            end
        end
    end

    // Run-length register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ones_cnt_q <= '0;
        end else begin
            ones_cnt_q <= ones_cnt_d;
        end
    end

endmodule

// File: rtl/sipo_block.sv
// Receive deserializer: SYNC hunt, bit unstuffing and LSB-first byte assembly.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  HUNT    | shifting bits through sync_sr looking for SYNC_PATTERN
//  RECEIVE | SYNC found; unstuffing and assembling bytes until EOP/error
module sipo_block
    import usb_sie_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  serial_ip,
    input  logic                  bit_valid,
    input  logic                  eop,
    output logic [DATA_WIDTH-1:0] parallel_op,
    output logic                  byte_valid,
    output logic                  rx_active,
    output logic                  stuff_err,
    output logic                  eop_err
);

    rx_state_e             state_q, state_d;
    // Bit 0 of each shift register only ever shifts out unread, so it is not stored.
    logic [SYNC_W-1:1]     sync_sr_q, sync_sr_d;
    logic [DATA_WIDTH-1:1] data_sr_q, data_sr_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] parallel_q, parallel_d;
    logic                  byte_valid_q, byte_valid_d;
    logic                  stuff_err_q, stuff_err_d;
    logic                  eop_err_q, eop_err_d;

    logic [SYNC_W-1:0]     sync_shift;
    logic [DATA_WIDTH-1:0] data_shift;
    logic                  sync_hit;
    logic                  rx_bit;
    logic                  drop_bit;
    logic                  stuff_violation;

    assign sync_shift = {serial_ip, sync_sr_q};
    assign data_shift = {serial_ip, data_sr_q};
    // EOP wins over a coincident bit, so the unstuffer never sees that bit.
    assign rx_bit     = bit_valid & (state_q == RECEIVE) & ~eop;

    sipo_unstuff u_unstuff (
        .clk             (clk),
        .reset           (reset),
        .bit_valid       (rx_bit),
        .serial_ip       (serial_ip),
        .clear           (state_d == HUNT),
        .seed            (sync_hit),
        .drop_bit        (drop_bit),
        .stuff_violation (stuff_violation)
    );

    // Next-state, datapath and strobe decode.
    always_comb begin
        state_d      = state_q;
        sync_sr_d    = sync_sr_q;
        data_sr_d    = data_sr_q;
        bit_cnt_d    = bit_cnt_q;
        parallel_d   = parallel_q;
        byte_valid_d = 1'b0;
        stuff_err_d  = 1'b0;
        eop_err_d    = 1'b0;
        sync_hit     = 1'b0;

        case (state_q)
            HUNT: begin
                if (bit_valid) begin
                    if (sync_shift == SYNC_PATTERN) begin
                        sync_hit  = 1'b1;
                        state_d   = RECEIVE;
                        bit_cnt_d = '0;
                        sync_sr_d = '0;
                    end else begin
                        sync_sr_d = sync_shift[SYNC_W-1:1];
                    end
                end
            end

            RECEIVE: begin
                if (eop) begin
                    state_d   = HUNT;
                    eop_err_d = (bit_cnt_q != '0);
                    bit_cnt_d = '0;
                end else if (bit_valid) begin
                    if (stuff_violation) begin
                        stuff_err_d = 1'b1;
                        state_d     = HUNT;
                        bit_cnt_d   = '0;
                    end else if (!drop_bit) begin
                        data_sr_d = data_shift[DATA_WIDTH-1:1];
                        if (bit_cnt_q == BIT_CNT_W'(DATA_WIDTH - 1)) begin
                            parallel_d   = data_shift;
                            byte_valid_d = 1'b1;
                            bit_cnt_d    = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        end
                    end
                end
            end

            default: begin
                state_d = HUNT;
            end
        endcase
    end

    // State, shift registers and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= HUNT;
            sync_sr_q    <= '0;
            data_sr_q    <= '0;
            bit_cnt_q    <= '0;
            parallel_q   <= '0;
            byte_valid_q <= 1'b0;
            stuff_err_q  <= 1'b0;
            eop_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_sr_q    <= sync_sr_d;
            data_sr_q    <= data_sr_d;
            bit_cnt_q    <= bit_cnt_d;
            parallel_q   <= parallel_d;
            byte_valid_q <= byte_valid_d;
            stuff_err_q  <= stuff_err_d;
            eop_err_q    <= eop_err_d;
        end
    end

    assign parallel_op = parallel_q;
    assign byte_valid  = byte_valid_q;
    assign stuff_err   = stuff_err_q;
    assign eop_err     = eop_err_q;
    assign rx_active   = (state_q == RECEIVE);

endmodule

// File: tb/tb_sipo_block.sv
// Scoreboard bench for sipo_block: stimulus queues expected events, monitor checks strobes.
module tb_sipo_block;
    import usb_sie_pkg::*;

    logic                  clk;
    logic                  reset;
    logic                  serial_ip;
    logic                  bit_valid;
    logic                  eop;
    logic [DATA_WIDTH-1:0] parallel_op;
    logic                  byte_valid;
    logic                  rx_active;
    logic                  stuff_err;
    logic                  eop_err;

    typedef enum logic [1:0] {EV_BYTE, EV_STUFF, EV_EOPERR} ev_kind_e;
    typedef struct {
        ev_kind_e              kind;
        logic [DATA_WIDTH-1:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fails  = 0;

    sipo_block dut (
        .clk         (clk),
        .reset       (reset),
        .serial_ip   (serial_ip),
        .bit_valid   (bit_valid),
        .eop         (eop),
        .parallel_op (parallel_op),
        .byte_valid  (byte_valid),
        .rx_active   (rx_active),
        .stuff_err   (stuff_err),
        .eop_err     (eop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input ev_kind_e k, input logic [DATA_WIDTH-1:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic mon_check(input ev_kind_e k);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fails++;
            $display("FAIL unexpected_event: got kind %0d data 0x%0h, expected none at %0t",
                     k, parallel_op, $time);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || ((k != EV_STUFF) && (parallel_op !== e.data))) begin
                n_fails++;
                $display("FAIL event: got kind %0d data 0x%0h expected kind %0d data 0x%0h at %0t",
                         k, parallel_op, e.kind, e.data, $time);
            end
        end
    endtask

    // Monitor: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (reset) begin
            if (byte_valid) mon_check(EV_BYTE);
            if (stuff_err)  mon_check(EV_STUFF);
            if (eop_err)    mon_check(EV_EOPERR);
        end
    end

    task automatic send_bit(input logic b);
        serial_ip = b;
        bit_valid = 1'b1;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
    endtask

    // Bit followed by an idle cycle carrying the inverted value, which must be ignored.
    task automatic send_bit_gap(input logic b);
        send_bit(b);
        serial_ip = ~b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_sync_pre;
        for (int i = 0; i < 7; i++) send_bit(1'b0);
    endtask

    task automatic send_sync;
        send_sync_pre();
        send_bit(1'b1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic send_eop;
        eop = 1'b1;
        @(posedge clk);
        #1;
        eop = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] bv;

    initial begin
        reset     = 1'b0;
        serial_ip = 1'b0;
        bit_valid = 1'b0;
        eop       = 1'b0;
        idle(2);
        chk("reset_parallel", parallel_op, 8'h00);
        chk("reset_rx_active", rx_active, 0);
        chk("reset_strobes", {byte_valid, stuff_err, eop_err}, 0);
        @(negedge clk);
        reset = 1'b1;
        idle(2);

        // 1: SYNC + A5
        send_sync_pre();
        chk("t1_rx_before_sync", rx_active, 0);
        send_bit(1'b1);
        chk("t1_rx_after_sync", rx_active, 1);
        push(EV_BYTE, 8'hA5);
        send_byte(8'hA5);
        send_eop();
        chk("t1_rx_after_eop", rx_active, 0);
        idle(2);

        // 2: FF; trailing SYNC 1 plus five data 1s force a stuffed 0
        send_sync();
        push(EV_BYTE, 8'hFF);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        chk("t2_no_byte_at_8", byte_valid, 0);
        send_bit(1'b1);
        chk("t2_byte_at_9", byte_valid, 1);
        chk("t2_no_stuff_err", stuff_err, 0);
        send_eop();
        idle(2);

        // 3: stuff violation
        send_sync();
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        push(EV_STUFF, 8'h00);
        send_bit(1'b1);
        chk("t3_stuff_err", stuff_err, 1);
        chk("t3_rx_dropped", rx_active, 0);
        idle(2);

        // 4: byte then partial byte then EOP
        send_sync();
        push(EV_BYTE, 8'h3C);
        send_byte(8'h3C);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        push(EV_EOPERR, 8'h3C);
        send_eop();
        chk("t4_eop_err", eop_err, 1);
        chk("t4_rx_after_eop", rx_active, 0);
        chk("t4_parallel_held", parallel_op, 8'h3C);
        idle(2);

        // 5: bit_valid toggling, then EOP with a coincident bit at a byte boundary
        for (int i = 0; i < 7; i++) send_bit_gap(1'b0);
        send_bit_gap(1'b1);
        push(EV_BYTE, 8'hA5);
        bv = 8'hA5;
        for (int i = 0; i < 8; i++) send_bit_gap(bv[i]);
        serial_ip = 1'b1;
        bit_valid = 1'b1;
        eop       = 1'b1;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        eop       = 1'b0;
        chk("t5_no_eop_err", eop_err, 0);
        chk("t5_rx_after_eop", rx_active, 0);
        chk("t5_parallel_held", parallel_op, 8'hA5);
        idle(2);

        // 6: reset mid-byte, then fresh packet
        send_sync();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        reset = 1'b0;
        #1;
        chk("t6_reset_parallel", parallel_op, 8'h00);
        chk("t6_reset_rx", rx_active, 0);
        chk("t6_reset_strobes", {byte_valid, stuff_err, eop_err}, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(1);
        send_sync();
        push(EV_BYTE, 8'h5A);
        send_byte(8'h5A);
        send_eop();
        idle(2);

        // 7: stuffed bit straight after a byte boundary
        send_sync();
        push(EV_BYTE, 8'hFC);
        send_byte(8'hFC);
        chk("t7_byte_at_boundary", byte_valid, 1);
        send_bit(1'b0);
        chk("t7_no_stuff_err", stuff_err, 0);
        push(EV_BYTE, 8'h01);
        send_byte(8'h01);
        send_eop();
        idle(3);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
